// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
//
// Return-change stage beside the next-state calculator. On a return request,
// or when the idle timer reaches zero, it latches the current balance. It then
// pays the balance out greedily, one coin per cycle, largest fitting
// denomination first. Each dispensed coin's value is presented on
// return_total together with return_signal, so the calculator can subtract it
// from the balance.
//
// Ports:
//   clk               system clock, rising-edge active
//   reset             synchronous, active-high reset
//   i_trigger_return  user return request (level-sampled in IDLE only)
//   wait_time         idle countdown; 0 means expired (sampled in IDLE only)
//   current_total     balance held by the system (latched in LOAD)
//   coin_value_flat   coin value i in bits [32*i+31:32*i], ascending, nonzero
//   o_return_coin     one-hot coin dispensed this cycle
//   return_total      value of the coin dispensed this cycle, else 0
//   return_signal     high exactly on cycles where a coin is dispensed
//   o_busy            high in LOAD and DISPENSE
//   o_done            one-cycle pulse when a payout finishes
//   o_residue         undispensable remainder, valid with o_done, held until
//                     the next LOAD
//
// Handshake: return_signal is a valid-only strobe with no ready. The
// calculator must accept the coin (o_return_coin / return_total) in the same
// cycle that return_signal is high. The stage never stalls, and it never
// presents a coin value while return_signal is low.
//
// TOTAL_BITS is expected to be <= 32. Coin values are compared after
// truncation to TOTAL_BITS.
// -----------------------------------------------------------------------------
module change_dispenser #(
  parameter int NUM_COINS  = 3,
  parameter int TOTAL_BITS = 31
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_trigger_return,
  input  logic [31:0]             wait_time,
  input  logic [TOTAL_BITS-1:0]   current_total,
  input  logic [32*NUM_COINS-1:0] coin_value_flat,
  output logic [NUM_COINS-1:0]    o_return_coin,
  output logic [TOTAL_BITS-1:0]   return_total,
  output logic                    return_signal,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [TOTAL_BITS-1:0]   o_residue
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [TOTAL_BITS-1:0] remaining_q, remaining_d;
  logic [TOTAL_BITS-1:0] residue_q, residue_d;

  // Coin values truncated to the balance width.
  logic [TOTAL_BITS-1:0] coin_val [NUM_COINS];

  always_comb begin
    for (int i = 0; i < NUM_COINS; i++) begin
      coin_val[i] = coin_value_flat[32*i +: TOTAL_BITS];
    end
  end

  // Highest-index coin that fits in the remaining balance. The loop runs in
  // ascending order, so the last match wins. A coin whose truncated value is
  // zero never counts as fitting. Otherwise it would "fit" forever and the
  // payout would never terminate.
  logic                  fit_found;
  logic [NUM_COINS-1:0]  fit_onehot;
  logic [TOTAL_BITS-1:0] fit_val;

  always_comb begin
    fit_found  = 1'b0;
    fit_onehot = '0;
    fit_val    = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if ((coin_val[i] != '0) && (coin_val[i] <= remaining_q)) begin
        fit_found     = 1'b1;
        fit_onehot    = '0;
        fit_onehot[i] = 1'b1;
        fit_val       = coin_val[i];
      end
    end
  end

  logic start_req;
  assign start_req = (i_trigger_return || (wait_time == 32'd0)) &&
                     (current_total != '0);

  // Next-state and combinational outputs.
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    residue_d     = residue_q;
    o_return_coin = '0;
    return_total  = '0;
    return_signal = 1'b0;
    o_busy        = 1'b0;
    o_done        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        o_busy      = 1'b1;
        remaining_d = current_total;
        residue_d   = '0;
        state_d     = ST_DISPENSE;
      end

      ST_DISPENSE: begin
        o_busy = 1'b1;
        if (fit_found) begin
          o_return_coin = fit_onehot;
          return_total  = fit_val;
          return_signal = 1'b1;
          // No underflow: the coin was chosen only if fit_val <= remaining.
          remaining_d   = remaining_q - fit_val;
        end else begin
          // Nothing fits (this includes remaining == 0). What is left over is
          // the residue.
          residue_d = remaining_q;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      residue_q   <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      residue_q   <= residue_d;
    end
  end

  assign o_residue = residue_q;

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
//
// Table-driven payouts with fixed coins {100,500,1000}, hand-written corner
// sequences (zero balance, reset mid-payout, coins inserted during a payout),
// and randomized payouts. The randomized payouts are checked against a greedy
// division-based reference model.
// -----------------------------------------------------------------------------
module tb_change_dispenser;

  localparam int NC = 3;
  localparam int TB = 31;

  logic            clk = 1'b0;
  logic            reset;
  logic            i_trigger_return;
  logic [31:0]     wait_time;
  logic [TB-1:0]   current_total;
  logic [32*NC-1:0] coin_value_flat;
  logic [NC-1:0]   o_return_coin;
  logic [TB-1:0]   return_total;
  logic            return_signal;
  logic            o_busy;
  logic            o_done;
  logic [TB-1:0]   o_residue;

  change_dispenser #(.NUM_COINS(NC), .TOTAL_BITS(TB)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_trigger_return (i_trigger_return),
    .wait_time        (wait_time),
    .current_total    (current_total),
    .coin_value_flat  (coin_value_flat),
    .o_return_coin    (o_return_coin),
    .return_total     (return_total),
    .return_signal    (return_signal),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_residue        (o_residue)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- scoreboard
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cv [NC];
  logic [1:0]  exp_q [$];   // expected coin indices, in dispense order
  logic [TB-1:0] model_res;
  int unsigned model_k;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_coins(input int unsigned a, input int unsigned b, input int unsigned c);
    cv[0] = a; cv[1] = b; cv[2] = c;
    coin_value_flat = {c, b, a};
  endtask

  // Greedy change by division: for each denomination from largest down,
  // take as many as fit.
  function automatic void model(input logic [TB-1:0] total);
    longint unsigned rem, v, n;
    exp_q.delete();
    rem = total;
    for (int i = NC - 1; i >= 0; i--) begin
      v = cv[i] & 32'h7FFF_FFFF;
      if (v != 0) begin
        n = rem / v;
        for (longint unsigned j = 0; j < n; j++) exp_q.push_back(i[1:0]);
        rem = rem % v;
      end
    end
    model_res = rem[TB-1:0];
    model_k   = exp_q.size();
  endfunction

  // ---------------------------------------------------------------- driver
  // Starts a payout, then follows it cycle by cycle. Cycle numbers are counted
  // relative to the edge that samples the trigger. If disturb is set, the
  // balance is raised to 5000 and the trigger is re-pulsed during DISPENSE.
  task automatic run_payout(input logic [TB-1:0] total, input bit use_wait,
                            input int unsigned exp_k, input logic [TB-1:0] exp_res,
                            input bit disturb, input string tag);
    int  cyc, k, idx;
    bit  done_seen;
    model(total);
    @(posedge clk); #1;
    current_total = total;
    if (use_wait) wait_time = 32'd0; else i_trigger_return = 1'b1;
    @(posedge clk); #1;
    i_trigger_return = 1'b0;
    wait_time = 32'd100;
    cyc = 1; k = 0; done_seen = 1'b0;
    @(negedge clk);
    check({tag, " load_busy"}, o_busy, 1);
    check({tag, " load_nocoin"}, return_signal, 0);
    while (!done_seen && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      if (disturb && cyc == 2) begin current_total = 5000; i_trigger_return = 1'b1; end
      if (disturb && cyc == 3) i_trigger_return = 1'b0;
      @(negedge clk);
      if (return_signal) begin
        k++;
        check({tag, " onehot"}, $countones(o_return_coin), 1);
        if (exp_q.size() == 0) begin
          check({tag, " extra_coin"}, 1, 0);
        end else begin
          idx = int'(exp_q.pop_front());
          check({tag, " coin_idx"}, o_return_coin, 64'(1) << idx);
          check({tag, " coin_val"}, return_total, cv[idx] & 32'h7FFF_FFFF);
        end
      end else begin
        check({tag, " idle_coin"}, {o_return_coin, return_total}, 0);
      end
      if (o_done) begin
        done_seen = 1'b1;
        check({tag, " done_busy"}, o_busy, 0);
        check({tag, " residue"}, o_residue, exp_res);
      end
    end
    check({tag, " done_seen"}, done_seen, 1);
    check({tag, " coins"}, k, exp_k);
    check({tag, " latency"}, cyc, 3 + exp_k);
    check({tag, " queue_empty"}, exp_q.size(), 0);
    @(negedge clk);
    check({tag, " residue_held"}, o_residue, exp_res);
    check({tag, " done_pulse"}, o_done, 0);
    check({tag, " no_restart"}, o_busy, 0);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [TB-1:0] total;
    bit            use_wait;
    int unsigned   exp_k;
    logic [TB-1:0] exp_res;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1600, 1'b0, 3, 0};
    vecs[1] = '{2000, 1'b1, 2, 0};
    vecs[2] = '{150,  1'b0, 1, 50};
    vecs[3] = '{3700, 1'b0, 6, 0};
    vecs[4] = '{99,   1'b0, 0, 99};
    vecs[5] = '{1,    1'b1, 0, 1};
    vecs[6] = '{1850, 1'b1, 5, 50};

    reset = 1'b1; i_trigger_return = 1'b0; wait_time = 32'd100; current_total = '0;
    set_coins(100, 500, 1000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_coin", o_return_coin, 0);
    check("rst_total", return_total, 0);
    check("rst_signal", return_signal, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_residue", o_residue, 0);
    @(posedge clk); #1 reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_payout(vecs[i].total, vecs[i].use_wait, vecs[i].exp_k, vecs[i].exp_res, 1'b0,
                 $sformatf("vec%0d", i));
    end

    // Zero balance with the trigger held: nothing happens.
    @(posedge clk); #1;
    current_total = '0; i_trigger_return = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("zero_busy", o_busy, 0);
      check("zero_done", o_done, 0);
      check("zero_signal", return_signal, 0);
      @(posedge clk); #1;
    end
    i_trigger_return = 1'b0;

    // Reset during the second DISPENSE cycle of a 3000 payout.
    @(posedge clk); #1;
    current_total = 3000; i_trigger_return = 1'b1;
    @(posedge clk); #1;
    i_trigger_return = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmid_coin1_sig", return_signal, 1);
    check("rstmid_coin1_val", return_total, 1000);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rstmid_busy", o_busy, 0);
    check("rstmid_signal", return_signal, 0);
    check("rstmid_coin", o_return_coin, 0);
    check("rstmid_total", return_total, 0);
    check("rstmid_done", o_done, 0);
    check("rstmid_residue", o_residue, 0);
    @(negedge clk);
    check("rstmid_idle", o_busy, 0);
    run_payout(1600, 1'b0, 3, 0, 1'b0, "after_rst");

    // Balance raised and trigger re-pulsed during a 600 payout.
    run_payout(600, 1'b0, 2, 0, 1'b1, "insert");
    current_total = '0;

    // Randomized coin sets and balances against the model.
    for (int r = 0; r < 20; r++) begin
      int unsigned a, b, c;
      logic [TB-1:0] t;
      a = $urandom_range(50, 1);
      b = a + $urandom_range(200, 1);
      c = b + $urandom_range(500, 1);
      set_coins(a, b, c);
      t = TB'($urandom_range(3000, 1));
      model(t);
      run_payout(t, bit'($urandom_range(1, 0)), model_k, model_res, 1'b0,
                 $sformatf("rnd%0d", r));
      current_total = '0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
